// File: rtl/locked_reg_bank.sv
// Bank of write-lockable configuration registers with a two-beat unlock key,
// a reset-only hard lock and a saturating access-violation counter.
module locked_reg_bank #(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 8,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] KEY0      = 16'hA5A5,
  parameter logic [WIDTH-1:0] KEY1      = 16'h5A5A
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      lock_req,
  input  logic                      hard_lock_req,
  input  logic                      key_valid,
  input  logic [WIDTH-1:0]          key_data,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*WIDTH-1:0] data_out,
  output logic [NUM_REGS-1:0]       locked,
  output logic                      hard_locked,
  output logic                      viol_pulse,
  output logic [7:0]                viol_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    GOT_K0 = 1'b1
  } key_state_t;

  key_state_t          key_state, key_state_nxt;
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] lock_bits, lock_nxt;
  logic                wr_in_range, rd_in_range;
  logic                wr_ok, wr_viol, key_viol, unlock, any_viol;

  // Range checks collapse to constants when the address space is fully populated.
  if (NUM_REGS == (1 << ADDR_W)) begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range = (int'(wr_addr) < NUM_REGS);
    assign rd_in_range = (int'(rd_addr) < NUM_REGS);
  end

  assign wr_ok    = wr_en && wr_in_range && !lock_bits[wr_addr];
  assign wr_viol  = wr_en && (!wr_in_range || lock_bits[wr_addr]);
  assign any_viol = wr_viol || key_viol;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    key_state_nxt = IDLE;
    key_viol      = 1'b0;
    unlock        = 1'b0;
    if (key_valid) begin
      if (hard_locked) begin
        key_viol = 1'b1;
      end else begin
        unique case (key_state)
          IDLE: begin
            if (key_data == KEY0) key_state_nxt = GOT_K0;
            else                  key_viol      = 1'b1;
          end
          GOT_K0: begin
            if (key_data == KEY1) unlock   = 1'b1;
            else                  key_viol = 1'b1;
          end
          default: key_viol = 1'b0;
        endcase
      end
    end
  end

  // Lock requests are applied after the unlock so they win in a shared cycle.
  always_comb begin
    lock_nxt = lock_bits;
    if (unlock)                  lock_nxt          = '0;
    if (lock_req && wr_in_range) lock_nxt[wr_addr] = 1'b1;
    if (hard_lock_req)           lock_nxt          = '1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes write gating see the old lock bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the bank is reset element by element because the protected outputs
      // must come up at RESET_VAL, unlike a RAM whose contents may stay undefined.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      lock_bits   <= '0;
      hard_locked <= 1'b0;
      key_state   <= IDLE;
      rd_data     <= '0;
      viol_pulse  <= 1'b0;
      viol_count  <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      lock_bits <= lock_nxt;
      if (hard_lock_req) hard_locked <= 1'b1;
      key_state  <= key_state_nxt;
      rd_data    <= rd_in_range ? regs[rd_addr] : '0;
      viol_pulse <= any_viol;
      if (any_viol && (viol_count != 8'hFF)) viol_count <= viol_count + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_data_out
    assign data_out[i*WIDTH +: WIDTH] = regs[i];
  end

  assign locked = lock_bits;

endmodule
